// File: rtl/index_extractor_rr_if.sv
// -----------------------------------------------------------------------------
// index_extractor_rr_if
// Purpose : AXI AR/AW address-request channels feeding the DRAM-cache index
//           extractor. Signal names follow the extractor's port view: the _i
//           signals are inputs to the slave and _o signals are outputs from it.
// Signals : arid_i, araddr_i, arvalid_i, arready_o   -- read address channel
//           awid_i, awaddr_i, awvalid_i, awready_o   -- write address channel
// Modports: master (upstream AXI front-end), slave (index_extractor_rr)
// -----------------------------------------------------------------------------
interface index_extractor_rr_if #(
   parameter int ID_W   = 32,
   parameter int ADDR_W = 32
);
   logic [ID_W-1:0]   arid_i;
   logic [ADDR_W-1:0] araddr_i;
   logic              arvalid_i;
   logic              arready_o;
   logic [ID_W-1:0]   awid_i;
   logic [ADDR_W-1:0] awaddr_i;
   logic              awvalid_i;
   logic              awready_o;

   modport master (
      output arid_i, araddr_i, arvalid_i,
      output awid_i, awaddr_i, awvalid_i,
      input  arready_o, awready_o
   );

   modport slave (
      input  arid_i, araddr_i, arvalid_i,
      input  awid_i, awaddr_i, awvalid_i,
      output arready_o, awready_o
   );
endinterface

// File: rtl/index_extractor_rr.sv
// -----------------------------------------------------------------------------
// index_extractor_rr
// Purpose : Accepts AXI AR and AW address requests, arbitrates round-robin when
//           both are valid, computes the cache set index of the accepted
//           address and pushes one tagged descriptor per request into the
//           downstream tag-lookup request FIFO (1-cycle registered latency).
// Ports   : clk             - single clock, rising edge
//           rst             - synchronous reset, active-high
//           axi             - AR/AW request channels (index_extractor_rr_if.slave)
//           index_o         - set index of the most recently accepted request
//           fifo_afull_i    - downstream FIFO almost-full (drops both readies)
//           fifo_write_en_o - push strobe
//           fifo_data_o     - descriptor {zero pad, is_wr, id, addr}
// Config  : INDEX_HASH_EN - when defined, the index is the XOR of the plain
//           index field with the next INDEX_W address bits above it.
// -----------------------------------------------------------------------------
module index_extractor_rr #(
   parameter int ID_W        = 32,
   parameter int ADDR_W      = 32,
   parameter int OFFSET_W    = 6,
   parameter int INDEX_W     = 4,
   parameter int FIFO_DATA_W = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   index_extractor_rr_if.slave    axi,
   output logic [INDEX_W-1:0]     index_o,
   input  logic                   fifo_afull_i,
   output logic                   fifo_write_en_o,
   output logic [FIFO_DATA_W-1:0] fifo_data_o
);

   if (FIFO_DATA_W < 1 + ID_W + ADDR_W) begin : g_bad_fifo_w
      $error("index_extractor_rr: FIFO_DATA_W must be >= 1+ID_W+ADDR_W");
   end
`ifdef INDEX_HASH_EN
   if (ADDR_W < OFFSET_W + 2*INDEX_W) begin : g_bad_hash_w
      $error("index_extractor_rr: INDEX_HASH_EN needs ADDR_W >= OFFSET_W+2*INDEX_W");
   end
`endif

   logic                   prio_rd_q, prio_rd_d;
   logic                   wen_q, wen_d;
   logic [INDEX_W-1:0]     index_q, index_d;
   logic [FIFO_DATA_W-1:0] data_q, data_d;

   logic                   ar_hs, aw_hs;
   logic [ID_W-1:0]        sel_id;
   logic [ADDR_W-1:0]      sel_addr;

   // Readies are mutually exclusive when both valids are high, so at most
   // one handshake can happen per cycle; a lone valid ignores the priority.
   assign axi.arready_o = !rst && !fifo_afull_i && (!axi.awvalid_i ||  prio_rd_q);
   assign axi.awready_o = !rst && !fifo_afull_i && (!axi.arvalid_i || !prio_rd_q);

   assign ar_hs = axi.arvalid_i && axi.arready_o;
   assign aw_hs = axi.awvalid_i && axi.awready_o;

   assign sel_id   = aw_hs ? axi.awid_i   : axi.arid_i;
   assign sel_addr = aw_hs ? axi.awaddr_i : axi.araddr_i;

   always_comb begin
      prio_rd_d = prio_rd_q;
      wen_d     = 1'b0;
      index_d   = index_q;
      data_d    = data_q;
      if (ar_hs || aw_hs) begin
         // The granted channel hands priority to the other one.
         prio_rd_d = aw_hs;
         wen_d     = 1'b1;
`ifdef INDEX_HASH_EN
         index_d   = sel_addr[OFFSET_W +: INDEX_W] ^ sel_addr[OFFSET_W+INDEX_W +: INDEX_W];
`else
         index_d   = sel_addr[OFFSET_W +: INDEX_W];
`endif
         data_d                        = '0;
         data_d[ADDR_W-1:0]            = sel_addr;
         data_d[ADDR_W +: ID_W]        = sel_id;
         data_d[ADDR_W+ID_W]           = aw_hs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_rd_q <= 1'b1;
         wen_q     <= 1'b0;
         index_q   <= '0;
         data_q    <= '0;
      end else begin
         prio_rd_q <= prio_rd_d;
         wen_q     <= wen_d;
         index_q   <= index_d;
         data_q    <= data_d;
      end
   end

   assign index_o         = index_q;
   assign fifo_write_en_o = wen_q;
   assign fifo_data_o     = data_q;

endmodule

// File: tb/tb_index_extractor_rr.sv
module tb_index_extractor_rr;
   localparam int ID_W = 32, ADDR_W = 32, OFFSET_W = 6, INDEX_W = 4, FIFO_DATA_W = 128;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [INDEX_W-1:0]     index_o;
   logic                   fifo_afull_i;
   logic                   fifo_write_en_o;
   logic [FIFO_DATA_W-1:0] fifo_data_o;

   int tests = 0;
   int fails = 0;

   index_extractor_rr_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

   index_extractor_rr #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
      .INDEX_W(INDEX_W), .FIFO_DATA_W(FIFO_DATA_W)
   ) dut (
      .clk(clk), .rst(rst), .axi(bus.slave),
      .index_o(index_o), .fifo_afull_i(fifo_afull_i),
      .fifo_write_en_o(fifo_write_en_o), .fifo_data_o(fifo_data_o)
   );

   always #5 clk = ~clk;

   function automatic logic [FIFO_DATA_W-1:0] desc(input logic is_wr,
                                                   input logic [31:0] id,
                                                   input logic [31:0] addr);
      logic [FIFO_DATA_W-1:0] d;
      d = '0;
      d[31:0]  = addr;
      d[63:32] = id;
      d[64]    = is_wr;
      return d;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
      bus.arid_i = '0; bus.araddr_i = '0; bus.awid_i = '0; bus.awaddr_i = '0;
      fifo_afull_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      bus.arvalid_i = 1'b1; bus.arid_i = 32'd9; bus.araddr_i = 32'h3C0;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests++;
         if (bus.arready_o !== 1'b0) begin
            fails++; $display("FAIL reset_arready: got %b want 0", bus.arready_o);
         end
         tick();
      end
      tests++;
      if (fifo_write_en_o !== 1'b0) begin
         fails++; $display("FAIL reset_wen: got %b want 0", fifo_write_en_o);
      end
      tests++;
      if (index_o !== 4'd0) begin
         fails++; $display("FAIL reset_index: got %0d want 0", index_o);
      end
      tests++;
      if (fifo_data_o !== '0) begin
         fails++; $display("FAIL reset_data: got %h want 0", fifo_data_o);
      end
      bus.arvalid_i = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_lone_read();
      bus.arid_i = 32'd5; bus.araddr_i = 32'd200; bus.arvalid_i = 1'b1;
      #1;
      tests++;
      if (bus.arready_o !== 1'b1) begin
         fails++; $display("FAIL lone_arready: got %b want 1", bus.arready_o);
      end
      tick();
      bus.arvalid_i = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b1) begin
         fails++; $display("FAIL lone_wen: got %b want 1", fifo_write_en_o);
      end
      tests++;
      if (index_o !== 4'd3) begin
         fails++; $display("FAIL lone_index: got %0d want 3", index_o);
      end
      tests++;
      if (fifo_data_o !== desc(1'b0, 32'd5, 32'd200)) begin
         fails++; $display("FAIL lone_data: got %h want %h", fifo_data_o, desc(1'b0, 32'd5, 32'd200));
      end
      tick();
      tests++;
      if (fifo_write_en_o !== 1'b0 || index_o !== 4'd3) begin
         fails++; $display("FAIL lone_hold: got wen=%b idx=%0d want wen=0 idx=3", fifo_write_en_o, index_o);
      end
   endtask

   task automatic test_contention();
      do_reset();
      bus.arid_i = 32'd0; bus.araddr_i = 32'h100; bus.arvalid_i = 1'b1;
      bus.awid_i = 32'd0; bus.awaddr_i = 32'h140; bus.awvalid_i = 1'b1;
      #1;
      tests++;
      if (bus.arready_o !== 1'b1 || bus.awready_o !== 1'b0) begin
         fails++; $display("FAIL cont_grant1: got ar=%b aw=%b want ar=1 aw=0", bus.arready_o, bus.awready_o);
      end
      tick();
      bus.arvalid_i = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b1 || index_o !== 4'd4 || fifo_data_o !== desc(1'b0, 32'd0, 32'h100)) begin
         fails++; $display("FAIL cont_push1: got wen=%b idx=%0d data=%h want wen=1 idx=4 data=%h",
                           fifo_write_en_o, index_o, fifo_data_o, desc(1'b0, 32'd0, 32'h100));
      end
      #1;
      tests++;
      if (bus.awready_o !== 1'b1) begin
         fails++; $display("FAIL cont_grant2: got aw=%b want 1", bus.awready_o);
      end
      tick();
      bus.awvalid_i = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b1 || index_o !== 4'd5 || fifo_data_o !== desc(1'b1, 32'd0, 32'h140)) begin
         fails++; $display("FAIL cont_push2: got wen=%b idx=%0d data=%h want wen=1 idx=5 data=%h",
                           fifo_write_en_o, index_o, fifo_data_o, desc(1'b1, 32'd0, 32'h140));
      end
      bus.arvalid_i = 1'b1; bus.awvalid_i = 1'b1;
      #1;
      tests++;
      if (bus.arready_o !== 1'b1 || bus.awready_o !== 1'b0) begin
         fails++; $display("FAIL cont_grant3: got ar=%b aw=%b want ar=1 aw=0", bus.arready_o, bus.awready_o);
      end
      bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
      tick();
      tests++;
      if (fifo_write_en_o !== 1'b0) begin
         fails++; $display("FAIL cont_withdraw: got wen=%b want 0", fifo_write_en_o);
      end
   endtask

   task automatic test_backpressure();
      // Priority is still with the read from the withdrawn contention.
      bus.arid_i = 32'd1; bus.araddr_i = 32'h080; bus.arvalid_i = 1'b1;
      bus.awid_i = 32'd2; bus.awaddr_i = 32'h0C0; bus.awvalid_i = 1'b1;
      fifo_afull_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.arready_o !== 1'b0 || bus.awready_o !== 1'b0) begin
            fails++; $display("FAIL bp_ready%0d: got ar=%b aw=%b want 0 0", c, bus.arready_o, bus.awready_o);
         end
         tick();
         tests++;
         if (fifo_write_en_o !== 1'b0 || index_o !== 4'd5) begin
            fails++; $display("FAIL bp_push%0d: got wen=%b idx=%0d want wen=0 idx=5", c, fifo_write_en_o, index_o);
         end
      end
      fifo_afull_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         logic want_wr;
         want_wr = (c % 2) == 1;
         #1;
         tests++;
         if (bus.arready_o !== !want_wr || bus.awready_o !== want_wr) begin
            fails++; $display("FAIL bp_rel_grant%0d: got ar=%b aw=%b want ar=%b aw=%b",
                              c, bus.arready_o, bus.awready_o, !want_wr, want_wr);
         end
         tick();
         tests++;
         if (fifo_write_en_o !== 1'b1 ||
             fifo_data_o !== (want_wr ? desc(1'b1, 32'd2, 32'h0C0) : desc(1'b0, 32'd1, 32'h080)) ||
             index_o !== (want_wr ? 4'd3 : 4'd2)) begin
            fails++; $display("FAIL bp_rel_push%0d: got wen=%b idx=%0d data=%h want wen=1 is_wr=%b",
                              c, fifo_write_en_o, index_o, fifo_data_o, want_wr);
         end
      end
      bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
      tick();
   endtask

   task automatic test_hash();
      logic [INDEX_W-1:0] exp_idx;
`ifdef INDEX_HASH_EN
      exp_idx = 4'd2;
`else
      exp_idx = 4'd3;
`endif
      bus.arid_i = 32'd7; bus.araddr_i = 32'h4C0; bus.arvalid_i = 1'b1;
      tick();
      bus.arvalid_i = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b1 || index_o !== exp_idx || fifo_data_o !== desc(1'b0, 32'd7, 32'h4C0)) begin
         fails++; $display("FAIL hash_index: got wen=%b idx=%0d data=%h want wen=1 idx=%0d",
                           fifo_write_en_o, index_o, fifo_data_o, exp_idx);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.arid_i = 32'd3; bus.araddr_i = 32'h040; bus.arvalid_i = 1'b1;
      tick();
      bus.arvalid_i = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b1 || index_o !== 4'd1) begin
         fails++; $display("FAIL mid_push: got wen=%b idx=%0d want wen=1 idx=1", fifo_write_en_o, index_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (fifo_write_en_o !== 1'b0 || index_o !== 4'd0 || fifo_data_o !== '0) begin
         fails++; $display("FAIL mid_rst_out: got wen=%b idx=%0d data=%h want 0 0 0",
                           fifo_write_en_o, index_o, fifo_data_o);
      end
      bus.arvalid_i = 1'b1; bus.awvalid_i = 1'b1;
      #1;
      tests++;
      if (bus.arready_o !== 1'b1 || bus.awready_o !== 1'b0) begin
         fails++; $display("FAIL mid_rst_prio: got ar=%b aw=%b want ar=1 aw=0", bus.arready_o, bus.awready_o);
      end
      bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_lone_read();
      test_contention();
      test_backpressure();
      test_hash();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
